// File: rtl/ahci_dma_pkg.sv
// Shared definitions for the AHCI DMA PRD sequencers: state encoding,
// AXI burst limit and the QWORD-count helper.
package ahci_dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN,
    ST_WDONE,
    ST_FLUSH,
    ST_ABORT
  } prd_state_e;

  localparam int AXI_MAX_BURST = 16;

  // Widened by one bit so a full-scale word count plus offset cannot wrap.
  function automatic logic [32:0] qword_count(input logic [1:0] woffs,
                                              input logic [31:0] wcnt);
    logic [32:0] sum;
    sum = {31'd0, woffs} + {1'b0, wcnt} + 33'd4;
    return sum >> 2;
  endfunction

endpackage

// File: rtl/ahci_dma_burst_split.sv
// Picks the next AXI burst length in QWORDs: the remaining count, clipped so
// the burst never crosses a 128-byte (16-QWORD) boundary.
module ahci_dma_burst_split
  import ahci_dma_pkg::*;
#(
  parameter int WCNT_BITS = 21
) (
  input  logic [3:0]           qaddr_lo,
  input  logic [WCNT_BITS-1:0] qrem,
  output logic [4:0]           len
);

  logic [4:0] room;

  always_comb begin
    room = 5'(AXI_MAX_BURST) - {1'b0, qaddr_lo};
    if (qrem < WCNT_BITS'(room)) begin
      len = qrem[4:0];
    end else begin
      len = room;
    end
  end

endmodule

// File: rtl/ahci_dma_rd_prd_seq.sv
// PRD sequencer for the host-to-device DMA read path: arms the realign FIFO,
// issues boundary-safe QWORD read bursts and tracks PRD/transfer completion.
module ahci_dma_rd_prd_seq
  import ahci_dma_pkg::*;
#(
  parameter int WCNT_BITS = 21,
  parameter int ADDR_BITS = 32
) (
  input  logic                 hclk,
  input  logic                 hrst,
  input  logic [ADDR_BITS-2:0] prd_addr,
  input  logic [WCNT_BITS-1:0] prd_wcnt,
  input  logic                 prd_last,
  input  logic                 prd_irq,
  input  logic                 prd_vld,
  output logic                 prd_rdy,
  input  logic                 abort,
  output logic                 fifo_start,
  output logic [WCNT_BITS-1:0] fifo_wcnt,
  output logic [1:0]           fifo_woffs,
  output logic                 fifo_last_prd,
  input  logic                 fifo_done,
  input  logic                 fifo_done_flush,
  output logic [ADDR_BITS-4:0] axi_araddr,
  output logic [3:0]           axi_arlen,
  output logic                 axi_arvalid,
  input  logic                 axi_arready,
  output logic                 busy,
  output logic                 prd_done,
  output logic                 irq_pulse,
  output logic                 xfer_done,
  output logic                 aborted
);

  localparam int QA_BITS = ADDR_BITS - 3;

  prd_state_e           state_q, state_d;
  logic [QA_BITS-1:0]   qaddr_q, qaddr_d;
  logic [WCNT_BITS-1:0] qrem_q, qrem_d, qrem_after;
  logic [WCNT_BITS-1:0] fifo_wcnt_q, fifo_wcnt_d;
  logic [1:0]           fifo_woffs_q, fifo_woffs_d;
  logic                 last_q, last_d;
  logic                 irq_q, irq_d;
  logic                 done_seen_q, done_seen_d;
  logic                 flush_seen_q, flush_seen_d;
  logic                 rdy_q, rdy_d;
  logic                 arvalid_q, arvalid_d;
  logic                 start_q, start_d;
  logic                 prd_done_q, prd_done_d;
  logic                 irq_pulse_q, irq_pulse_d;
  logic                 xfer_done_q, xfer_done_d;
  logic                 aborted_q, aborted_d;
  logic                 accept, hs;
  logic [4:0]           len;
  logic [32:0]          qsum;
  logic                 unused_qsum_hi;

  ahci_dma_burst_split #(
    .WCNT_BITS(WCNT_BITS)
  ) u_split (
    .qaddr_lo(qaddr_q[3:0]),
    .qrem    (qrem_q),
    .len     (len)
  );

  assign qsum           = qword_count(prd_addr[1:0], 32'(prd_wcnt));
  assign unused_qsum_hi = ^qsum[32:WCNT_BITS];

  always_comb begin
    accept       = (state_q == ST_IDLE) && rdy_q && prd_vld;
    hs           = arvalid_q && axi_arready;
    qrem_after   = qrem_q - WCNT_BITS'(len);
    state_d      = state_q;
    qaddr_d      = qaddr_q;
    qrem_d       = qrem_q;
    fifo_wcnt_d  = fifo_wcnt_q;
    fifo_woffs_d = fifo_woffs_q;
    last_d       = last_q;
    irq_d        = irq_q;
    done_seen_d  = done_seen_q | fifo_done;
    flush_seen_d = flush_seen_q | fifo_done_flush;
    arvalid_d    = arvalid_q;
    start_d      = 1'b0;
    prd_done_d   = 1'b0;
    irq_pulse_d  = 1'b0;
    xfer_done_d  = 1'b0;
    aborted_d    = 1'b0;

    if (hs) begin
      qaddr_d = qaddr_q + QA_BITS'(len);
      qrem_d  = qrem_after;
    end

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          qaddr_d      = prd_addr[ADDR_BITS-2:2];
          qrem_d       = qsum[WCNT_BITS-1:0];
          fifo_wcnt_d  = prd_wcnt;
          fifo_woffs_d = prd_addr[1:0];
          last_d       = prd_last;
          irq_d        = prd_irq;
          done_seen_d  = 1'b0;
          flush_seen_d = 1'b0;
          start_d      = 1'b1;
          arvalid_d    = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        // An address already offered must stay up until accepted.
        if (abort) begin
          arvalid_d = !hs;
          state_d   = ST_ABORT;
        end else if (hs && (qrem_after == '0)) begin
          arvalid_d = 1'b0;
          state_d   = ST_WDONE;
        end
      end
      ST_WDONE: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else if (done_seen_q) begin
          prd_done_d  = 1'b1;
          irq_pulse_d = irq_q;
          state_d     = last_q ? ST_FLUSH : ST_IDLE;
        end
      end
      ST_FLUSH: begin
        if (abort) begin
          state_d = ST_ABORT;
        end else if (flush_seen_q) begin
          xfer_done_d = 1'b1;
          state_d     = ST_IDLE;
        end
      end
      ST_ABORT: begin
        if (!arvalid_q || axi_arready) begin
          arvalid_d = 1'b0;
          aborted_d = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        arvalid_d = 1'b0;
        state_d   = ST_IDLE;
      end
    endcase

    rdy_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q      <= ST_IDLE;
      qaddr_q      <= '0;
      qrem_q       <= '0;
      fifo_wcnt_q  <= '0;
      fifo_woffs_q <= '0;
      last_q       <= 1'b0;
      irq_q        <= 1'b0;
      done_seen_q  <= 1'b0;
      flush_seen_q <= 1'b0;
      rdy_q        <= 1'b0;
      arvalid_q    <= 1'b0;
      start_q      <= 1'b0;
      prd_done_q   <= 1'b0;
      irq_pulse_q  <= 1'b0;
      xfer_done_q  <= 1'b0;
      aborted_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      qaddr_q      <= qaddr_d;
      qrem_q       <= qrem_d;
      fifo_wcnt_q  <= fifo_wcnt_d;
      fifo_woffs_q <= fifo_woffs_d;
      last_q       <= last_d;
      irq_q        <= irq_d;
      done_seen_q  <= done_seen_d;
      flush_seen_q <= flush_seen_d;
      rdy_q        <= rdy_d;
      arvalid_q    <= arvalid_d;
      start_q      <= start_d;
      prd_done_q   <= prd_done_d;
      irq_pulse_q  <= irq_pulse_d;
      xfer_done_q  <= xfer_done_d;
      aborted_q    <= aborted_d;
    end
  end

  assign prd_rdy       = rdy_q;
  assign busy          = (state_q != ST_IDLE);
  assign fifo_start    = start_q;
  assign fifo_wcnt     = fifo_wcnt_q;
  assign fifo_woffs    = fifo_woffs_q;
  assign fifo_last_prd = last_q;
  assign axi_arvalid   = arvalid_q;
  assign axi_araddr    = arvalid_q ? qaddr_q : '0;
  assign axi_arlen     = arvalid_q ? 4'(len - 5'd1) : 4'd0;
  assign prd_done      = prd_done_q;
  assign irq_pulse     = irq_pulse_q;
  assign xfer_done     = xfer_done_q;
  assign aborted       = aborted_q;

endmodule
